// File: rtl/scan_pkg.sv
// Shared definitions for the frame-sweep source and the downstream screen/address stages.
package scan_pkg;

    localparam int unsigned COORD_W        = 8;
    localparam int unsigned X_MAX_DEF      = 255;
    localparam int unsigned Y_MAX_DEF      = 255;
    localparam int unsigned PIPE_DEPTH_DEF = 5;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StDone
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] xcenter;
        logic [COORD_W-1:0] ycenter;
        logic [COORD_W-1:0] zoom;
        logic [COORD_W-1:0] angle;
    } view_t;

endpackage

// File: rtl/raster_counter.sv
// X/Y raster counter pair: X wraps at X_MAX and carries into Y; flags the last pixel of the sweep.
module raster_counter
    import scan_pkg::*;
#(
    parameter int unsigned X_MAX = X_MAX_DEF,
    parameter int unsigned Y_MAX = Y_MAX_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               last_o
);

    localparam logic [COORD_W-1:0] XLast = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YLast = COORD_W'(Y_MAX);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               x_wrap;
    logic               y_wrap;

    // Explicit compares so small sweeps never rely on the natural 8-bit rollover.
    assign x_wrap = (x_q == XLast);
    assign y_wrap = (y_q == YLast);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
        end else if (en_i) begin
            if (x_wrap) begin
                x_d = '0;
                y_d = y_wrap ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = x_wrap && y_wrap;

endmodule

// File: rtl/coord_scanner.sv
// Frame-sweep source: latches view parameters on Start, walks the source raster, drains the
// transform pipeline and pulses Done.
module coord_scanner
    import scan_pkg::*;
#(
    parameter int unsigned X_MAX      = X_MAX_DEF,
    parameter int unsigned Y_MAX      = Y_MAX_DEF,
    parameter int unsigned PIPE_DEPTH = PIPE_DEPTH_DEF
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic               Start,
    input  logic               Stall,
    input  logic [COORD_W-1:0] Xcenter_in,
    input  logic [COORD_W-1:0] Ycenter_in,
    input  logic [COORD_W-1:0] Zoom_in,
    input  logic [COORD_W-1:0] Angle_in,
    output logic [COORD_W-1:0] Xcenter,
    output logic [COORD_W-1:0] Ycenter,
    output logic [COORD_W-1:0] Zoom,
    output logic [COORD_W-1:0] Angle,
    output logic [COORD_W-1:0] Xcoord,
    output logic [COORD_W-1:0] Ycoord,
    output logic               ENB,
    output logic               Busy,
    output logic               Done
);

    localparam int unsigned       DrainW    = $clog2(PIPE_DEPTH + 1);
    localparam logic [DrainW-1:0] DrainInit = DrainW'(PIPE_DEPTH - 1);

    state_e            state_q, state_d;
    logic [DrainW-1:0] drain_q, drain_d;
    view_t             view_q, view_d;
    logic              enb_q, enb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_last;

    raster_counter #(
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_raster_counter (
        .clk_i  (ACLK),
        .rst_i  (ARESET),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .x_o    (Xcoord),
        .y_o    (Ycoord),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        view_d  = view_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StScan;
                    cnt_clr = 1'b1;
                    view_d  = '{xcenter: Xcenter_in, ycenter: Ycenter_in,
                                zoom: Zoom_in, angle: Angle_in};
                end
            end
            StScan: begin
                // The counter parks on the last pixel rather than wrapping past it.
                if (!Stall) begin
                    if (cnt_last) begin
                        state_d = StDrain;
                        drain_d = DrainInit;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (drain_q == '0) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        enb_d  = (state_d == StScan);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StIdle;
            drain_q <= '0;
            view_q  <= '0;
            enb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            view_q  <= view_d;
            enb_q   <= enb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Stall masks the presented pixel in the same cycle; the counters only hold.
    assign ENB     = enb_q & ~Stall;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Xcenter = view_q.xcenter;
    assign Ycenter = view_q.ycenter;
    assign Zoom    = view_q.zoom;
    assign Angle   = view_q.angle;

endmodule

// File: tb/tb_coord_scanner.sv
// Randomized bench for coord_scanner: three sweep geometries checked against a raster-list model.
module tb_coord_scanner;

    logic       clk;
    logic       arst;
    logic       start [3];
    logic       stall [3];
    logic [7:0] xci [3];
    logic [7:0] yci [3];
    logic [7:0] zi  [3];
    logic [7:0] ai  [3];
    logic [7:0] xcen [3];
    logic [7:0] ycen [3];
    logic [7:0] zoom [3];
    logic [7:0] ang  [3];
    logic [7:0] xco  [3];
    logic [7:0] yco  [3];
    logic       enb  [3];
    logic       busy [3];
    logic       done [3];

    int xm [3] = '{3, 0, 255};
    int ym [3] = '{1, 0, 255};
    int pd [3] = '{2, 3, 5};

    logic [7:0] exv_xc [3];
    logic [7:0] exv_yc [3];
    logic [7:0] exv_zm [3];
    logic [7:0] exv_an [3];

    int n_checks;
    int n_fails;

    coord_scanner #(.X_MAX(3), .Y_MAX(1), .PIPE_DEPTH(2)) u_dut0 (
        .ACLK(clk), .ARESET(arst), .Start(start[0]), .Stall(stall[0]),
        .Xcenter_in(xci[0]), .Ycenter_in(yci[0]), .Zoom_in(zi[0]), .Angle_in(ai[0]),
        .Xcenter(xcen[0]), .Ycenter(ycen[0]), .Zoom(zoom[0]), .Angle(ang[0]),
        .Xcoord(xco[0]), .Ycoord(yco[0]), .ENB(enb[0]), .Busy(busy[0]), .Done(done[0])
    );

    coord_scanner #(.X_MAX(0), .Y_MAX(0), .PIPE_DEPTH(3)) u_dut1 (
        .ACLK(clk), .ARESET(arst), .Start(start[1]), .Stall(stall[1]),
        .Xcenter_in(xci[1]), .Ycenter_in(yci[1]), .Zoom_in(zi[1]), .Angle_in(ai[1]),
        .Xcenter(xcen[1]), .Ycenter(ycen[1]), .Zoom(zoom[1]), .Angle(ang[1]),
        .Xcoord(xco[1]), .Ycoord(yco[1]), .ENB(enb[1]), .Busy(busy[1]), .Done(done[1])
    );

    coord_scanner #(.X_MAX(255), .Y_MAX(255), .PIPE_DEPTH(5)) u_dut2 (
        .ACLK(clk), .ARESET(arst), .Start(start[2]), .Stall(stall[2]),
        .Xcenter_in(xci[2]), .Ycenter_in(yci[2]), .Zoom_in(zi[2]), .Angle_in(ai[2]),
        .Xcenter(xcen[2]), .Ycenter(ycen[2]), .Zoom(zoom[2]), .Angle(ang[2]),
        .Xcoord(xco[2]), .Ycoord(yco[2]), .ENB(enb[2]), .Busy(busy[2]), .Done(done[2])
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_status(input int k, input logic e_enb, input logic e_busy,
                                input logic e_done);
        check_eq("enb", 32'(enb[k]), 32'(e_enb));
        check_eq("busy", 32'(busy[k]), 32'(e_busy));
        check_eq("done", 32'(done[k]), 32'(e_done));
        check_eq("xcenter", 32'(xcen[k]), 32'(exv_xc[k]));
        check_eq("ycenter", 32'(ycen[k]), 32'(exv_yc[k]));
        check_eq("zoom", 32'(zoom[k]), 32'(exv_zm[k]));
        check_eq("angle", 32'(ang[k]), 32'(exv_an[k]));
    endtask

    task automatic rand_inputs(input int k);
        xci[k] = 8'($urandom);
        yci[k] = 8'($urandom);
        zi[k]  = 8'($urandom);
        ai[k]  = 8'($urandom);
    endtask

    task automatic clear_view(input int k);
        exv_xc[k] = '0;
        exv_yc[k] = '0;
        exv_zm[k] = '0;
        exv_an[k] = '0;
    endtask

    // Called at #1 after a rising edge; returns at the same phase.
    task automatic run_frame(input int k, input int stall_pct, input int stall_idx,
                             input int abort_idx, input bit busy_start, input logic [7:0] xc,
                             input logic [7:0] yc, input logic [7:0] zm, input logic [7:0] an);
        logic [7:0] ex[$];
        logic [7:0] ey[$];
        int total, idx, cyc, nenb, held;
        for (int y = 0; y <= ym[k]; y++) begin
            for (int x = 0; x <= xm[k]; x++) begin
                ex.push_back(8'(x));
                ey.push_back(8'(y));
            end
        end
        total = ex.size();
        idx = 0; cyc = 0; nenb = 0; held = 0;

        start[k] = 1'b1; stall[k] = 1'b0;
        xci[k] = xc; yci[k] = yc; zi[k] = zm; ai[k] = an;
        @(negedge clk);
        check_status(k, 1'b0, 1'b0, 1'b0);
        exv_xc[k] = xc; exv_yc[k] = yc; exv_zm[k] = zm; exv_an[k] = an;
        @(posedge clk); #1;

        while (idx < total && cyc < 4 * total + 16) begin
            stall[k] = ($urandom_range(99) < stall_pct);
            if (idx == stall_idx && held < 3) begin
                stall[k] = 1'b1;
                held++;
            end
            if (idx == abort_idx) begin
                stall[k] = 1'b0;
                arst = 1'b1;
            end
            rand_inputs(k);
            start[k] = 1'b0;
            if (busy_start && idx == total / 2) begin
                start[k] = 1'b1;
                zi[k] = 8'h80;
            end
            @(negedge clk);
            check_status(k, !stall[k], 1'b1, 1'b0);
            check_eq("xcoord", 32'(xco[k]), 32'(ex[idx]));
            check_eq("ycoord", 32'(yco[k]), 32'(ey[idx]));
            if (enb[k]) nenb++;
            if (!stall[k]) idx++;
            cyc++;
            @(posedge clk); #1;
            if (arst) begin
                arst = 1'b0; start[k] = 1'b0; stall[k] = 1'b0;
                for (int j = 0; j < 3; j++) clear_view(j);
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    check_status(k, 1'b0, 1'b0, 1'b0);
                    check_eq("xcoord_rst", 32'(xco[k]), 32'd0);
                    check_eq("ycoord_rst", 32'(yco[k]), 32'd0);
                    @(posedge clk); #1;
                end
                return;
            end
        end
        check_eq("scan_len", idx, total);
        check_eq("enb_count", nenb, total);

        for (int d = 0; d < pd[k]; d++) begin
            stall[k] = 1'($urandom_range(1));
            start[k] = 1'($urandom_range(1));
            rand_inputs(k);
            @(negedge clk);
            check_status(k, 1'b0, 1'b1, 1'b0);
            @(posedge clk); #1;
        end

        start[k] = busy_start;
        stall[k] = 1'b0;
        @(negedge clk);
        check_status(k, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;

        start[k] = 1'b0;
        @(negedge clk);
        check_status(k, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        clk = 1'b0;
        arst = 1'b1;
        n_checks = 0;
        n_fails = 0;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            stall[k] = 1'b0;
            xci[k] = '0; yci[k] = '0; zi[k] = '0; ai[k] = '0;
            clear_view(k);
        end

        repeat (3) @(posedge clk);
        #1;
        arst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 3; k++) rand_inputs(k);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check_status(k, 1'b0, 1'b0, 1'b0);
                check_eq("xcoord_idle", 32'(xco[k]), 32'd0);
                check_eq("ycoord_idle", 32'(yco[k]), 32'd0);
            end
            @(posedge clk); #1;
        end

        // 4x2 sweep: plain frame, targeted stall, Start while busy, reset mid-frame.
        run_frame(0, 0, -1, -1, 1'b0, 8'h40, 8'h00, 8'h00, 8'h10);
        run_frame(0, 0, 2, -1, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
        run_frame(0, 0, -1, -1, 1'b1, 8'h05, 8'h06, 8'h20, 8'h07);
        run_frame(0, 0, -1, 5, 1'b0, 8'h99, 8'h88, 8'h77, 8'h66);
        run_frame(0, 0, -1, -1, 1'b0, 8'h12, 8'h34, 8'h56, 8'h78);
        for (int f = 0; f < 4; f++) begin
            run_frame(0, 35, -1, -1, f[0], 8'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom));
        end

        // Single-pixel sweep.
        run_frame(1, 0, -1, -1, 1'b0, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
        for (int f = 0; f < 3; f++) begin
            run_frame(1, 40, -1, -1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom));
        end

        // Full 256x256 sweep.
        run_frame(2, 0, -1, -1, 1'b0, 8'hFE, 8'h01, 8'h7F, 8'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
